// File: rtl/pool_window_reorder_if.sv
// Stream bundle for the 2x2 pool-window reorder stage: row-major pixels in,
// window-ordered pixels out (no downstream backpressure).
interface pool_window_reorder_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              win_last;
  logic              frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  win_last,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output win_last,
    output frame_done
  );
endinterface

// File: rtl/pool_window_reorder.sv
// Reorders a row-major feature-map stream into 2x2 pool windows (TL, TR, BL, BR).
// The even row is buffered; the odd row's pixel pair triggers a 4-cycle drain.
//
// state  | meaning
// ACCEPT | in_ready high; store pixel into row buffer / BL / BR hold
// EMIT0  | out_data = TL (row buffer, left column of window)
// EMIT1  | out_data = TR (row buffer, right column of window)
// EMIT2  | out_data = BL (hold_bl)
// EMIT3  | out_data = BR (hold_br), win_last, frame_done on final window
module pool_window_reorder #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pool_window_reorder_if.slave   bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  localparam logic [2:0] S_ACCEPT = 3'd0;
  localparam logic [2:0] S_EMIT0  = 3'd1;
  localparam logic [2:0] S_EMIT1  = 3'd2;
  localparam logic [2:0] S_EMIT2  = 3'd3;
  localparam logic [2:0] S_EMIT3  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  emit_col_q, emit_col_d;
  logic              frame_end_q, frame_end_d;
  logic [DATA_W-1:0] rowbuf_q [IMG_W];
  logic [DATA_W-1:0] rowbuf_d [IMG_W];
  logic [DATA_W-1:0] hold_bl_q, hold_bl_d;
  logic [DATA_W-1:0] hold_br_q, hold_br_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              win_last_q, win_last_d;
  logic              frame_done_q, frame_done_d;
  logic              xfer;

  assign xfer = bus.in_valid && (state_q == S_ACCEPT);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    emit_col_d   = emit_col_q;
    frame_end_d  = frame_end_q;
    rowbuf_d     = rowbuf_q;
    hold_bl_d    = hold_bl_q;
    hold_br_d    = hold_br_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    win_last_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (xfer) begin
          if (!row_q[0]) begin
            rowbuf_d[col_q] = bus.in_data;
          end else if (!col_q[0]) begin
            hold_bl_d = bus.in_data;
          end else begin
            // Outputs are registered, so TL is launched on the BR accept edge
            // to appear in the EMIT0 cycle.
            hold_br_d   = bus.in_data;
            emit_col_d  = col_q;
            frame_end_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            state_d     = S_EMIT0;
            out_valid_d = 1'b1;
            out_data_d  = rowbuf_q[col_q - 1'b1];
          end

          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_EMIT0: begin
        state_d     = S_EMIT1;
        out_valid_d = 1'b1;
        out_data_d  = rowbuf_q[emit_col_q];
      end
      S_EMIT1: begin
        state_d     = S_EMIT2;
        out_valid_d = 1'b1;
        out_data_d  = hold_bl_q;
      end
      S_EMIT2: begin
        state_d      = S_EMIT3;
        out_valid_d  = 1'b1;
        out_data_d   = hold_br_q;
        win_last_d   = 1'b1;
        frame_done_d = frame_end_q;
      end
      S_EMIT3: begin
        state_d = S_ACCEPT;
      end
      default: begin
        state_d = S_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      emit_col_q   <= '0;
      frame_end_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      emit_col_q   <= emit_col_d;
      frame_end_q  <= frame_end_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel storage carries no reset; its contents are rewritten before use.
  always_ff @(posedge clk) begin
    rowbuf_q  <= rowbuf_d;
    hold_bl_q <= hold_bl_d;
    hold_br_q <= hold_br_d;
  end

  assign bus.in_ready   = (state_q == S_ACCEPT);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;

endmodule
